shift_add_multiplier: RTL

//  - Sequential unsigned WIDTH x WIDTH multiplier, radix-2 shift-and-add, one partial product per clock.
//  - Consumer of 32-bit adder results: each iteration adds the multiplicand into the running upper half.
//  - Produces a 2*WIDTH-bit product on the same 64-bit result bus format the arithmetic unit uses.
//  - Sits between the operand registers and the arithmetic result mux; start/busy/done handshake.

---
 rtl/shift_add_multiplier_pkg.sv | 13 +
 rtl/shift_add_multiplier_datapath.sv | 66 ++++++
 rtl/shift_add_multiplier.sv | 77 +++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and FSM state encoding.
package shift_add_multiplier_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Datapath for the radix-2 shift-and-add multiplier: multiplicand register,
// partial-product register with carry bit, adder/shifter, iteration counter, result register.
module mult_datapath
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               latch,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               last,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH:0]   p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]     sum;

    always_comb begin
        sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        // NOTE: every _d takes its hold value first so no path can infer a latch.
        mcand_d  = mcand_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (load) begin
            mcand_d = op_a;
            p_d     = {{(WIDTH+1){1'b0}}, op_b};
            cnt_d   = '0;
        end else if (step) begin
            // Add into the upper half and shift right in one cycle; carry lands in the top product bit.
            p_d   = {1'b0, (p_q[0] ? sum : p_q[2*WIDTH:WIDTH]), p_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (latch) begin
                result_d = p_d[2*WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            mcand_q  <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign last   = (cnt_q == CNT_W'(WIDTH-1));
    assign result = result_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier with start/busy/done handshake;
// this level holds the control FSM, the datapath does the arithmetic.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   load, step, latch, last;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) begin
                    latch   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Outputs decoded from the next state so they are registered alongside it.
        busy_d = (state_d == ST_CALC) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .latch  (latch),
        .op_a   (opA),
        .op_b   (opB),
        .last   (last),
        .result (result)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
